// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-port responder: width codes, FSM states and
// the lane-mask/alignment decode that the CPU memory stage can reuse.
package data_mem_responder_pkg;

  localparam logic [3:0] WIDTH_B = 4'b0001;
  localparam logic [3:0] WIDTH_H = 4'b0011;
  localparam logic [3:0] WIDTH_W = 4'b1111;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  typedef struct packed {
    logic [3:0] lanes;
    logic       misaligned;
  } access_t;

  // Lanes are the unshifted width mask moved up to the byte offset, truncated to 4 bits
  function automatic access_t decode_access(input logic [3:0] width,
                                            input logic [1:0] offset);
    access_t w_acc;
    w_acc.lanes = width << offset;
    case (width)
      WIDTH_B: w_acc.misaligned = 1'b0;
      WIDTH_H: w_acc.misaligned = offset[0];
      WIDTH_W: w_acc.misaligned = (offset != 2'd0);
      default: w_acc.misaligned = 1'b1;
    endcase
    return w_acc;
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Word-organised storage with per-byte write enables and a combinational
// write-first read of the addressed word.
module data_mem_array #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic [3:0]            i_we,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rword
);

  logic [31:0] r_mem [2**DEPTH_LOG2];

  // Lanes being written this cycle are forwarded so the read sees the new data
  always_comb begin
    o_rword = r_mem[i_idx];
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) begin
        o_rword[8*b +: 8] = i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) begin
        r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Slave end of the RV32I data port: clear sequencer, address decode, alignment
// check and the registered, offset-aligned read path.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int DEPTH_LOG2     = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        width,
  input  logic              write_mem,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              misaligned_err
);

  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

  state_e                r_state;
  state_e                w_next_state;
  logic [DEPTH_LOG2-1:0] r_clear_idx;
  logic [31:0]           r_rdata;
  logic                  r_ready;
  logic                  r_misaligned;

  logic [1:0]            w_offset;
  logic [4:0]            w_shamt;
  logic [DEPTH_LOG2-1:0] w_index;
  access_t               w_acc;
  logic [31:0]           w_lane_data;
  logic [3:0]            w_arr_we;
  logic [DEPTH_LOG2-1:0] w_arr_idx;
  logic [31:0]           w_arr_wdata;
  logic [31:0]           w_rword;

  assign w_offset    = addr[1:0];
  assign w_shamt     = {w_offset, 3'b000};
  assign w_index     = addr[ADDR_W-1:2];
  assign w_acc       = decode_access(width, w_offset);
  assign w_lane_data = wdata << w_shamt;

  // Reset gates every array write so it takes priority over both clearing and stores
  always_comb begin
    w_next_state = r_state;
    w_arr_we     = 4'b0000;
    w_arr_idx    = w_index;
    w_arr_wdata  = w_lane_data;
    case (r_state)
      CLEAR: begin
        w_arr_we    = {4{rst_n}};
        w_arr_idx   = r_clear_idx;
        w_arr_wdata = 32'h0;
        if (r_clear_idx == LAST_IDX) begin
          w_next_state = READY;
        end
      end
      READY: begin
        if (rst_n && write_mem && !w_acc.misaligned) begin
          w_arr_we = w_acc.lanes;
        end
      end
      default: w_next_state = READY;
    endcase
  end

  data_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .i_we   (w_arr_we),
    .i_idx  (w_arr_idx),
    .i_wdata(w_arr_wdata),
    .o_rword(w_rword)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      r_clear_idx  <= '0;
      r_rdata      <= 32'h0;
      r_ready      <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == CLEAR) begin
        r_clear_idx <= r_clear_idx + 1'b1;
      end
      r_ready      <= (r_state == READY);
      r_rdata      <= (r_state == READY) ? (w_rword >> w_shamt) : 32'h0;
      r_misaligned <= (r_state == READY) && w_acc.misaligned;
    end
  end

  assign rdata          = r_rdata;
  assign ready          = r_ready;
  assign misaligned_err = r_misaligned;

endmodule
